// File: rtl/easyaxi_mst_rd_ctrl.sv
// -----------------------------------------------------------------------------
// easyaxi_mst_rd_ctrl
//   AXI4 read-master control stage. A session starts when rd_en is seen in IDLE.
//   The block then issues TXN_NUM INCR bursts on AR, with at most OST_DEPTH
//   bursts outstanding. It accepts R beats in order and holds rd_done high once
//   every burst has returned.
//
//   Optional feature macro: EASYAXI_RD_DATA_CHECK_EN
//     When this macro is defined, the data of every beat is compared with a
//     pattern made of copies of the beat address. A mismatch sets rd_err. When
//     it is undefined, rdata is ignored.
//
// Ports
//   clk, rst          clock (rising edge); synchronous active-high reset
//   rd_en             level input that starts and holds a read session
//   rd_done           level output; every burst of the session has returned
//   rd_err            sticky error flag; cleared when a session starts
//   axi_mst_ar*       AR channel (arvalid/arid/araddr/arlen/arsize/arburst out,
//                     arready in)
//   axi_mst_r*        R channel (rvalid/rid/rdata/rresp/rlast in, rready out)
// -----------------------------------------------------------------------------
module easyaxi_mst_rd_ctrl #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ID_WIDTH   = 4,
  parameter int                    OST_DEPTH  = 4,
  parameter int                    BURST_LEN  = 8,
  parameter int                    TXN_NUM    = 16,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = {ADDR_WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en,
  output logic                  rd_done,
  output logic                  rd_err,
  output logic                  axi_mst_arvalid,
  input  logic                  axi_mst_arready,
  output logic [ID_WIDTH-1:0]   axi_mst_arid,
  output logic [ADDR_WIDTH-1:0] axi_mst_araddr,
  output logic [7:0]            axi_mst_arlen,
  output logic [2:0]            axi_mst_arsize,
  output logic [1:0]            axi_mst_arburst,
  input  logic                  axi_mst_rvalid,
  output logic                  axi_mst_rready,
  input  logic [ID_WIDTH-1:0]   axi_mst_rid,
  input  logic [DATA_WIDTH-1:0] axi_mst_rdata,
  input  logic [1:0]            axi_mst_rresp,
  input  logic                  axi_mst_rlast
);

  localparam int BYTES       = DATA_WIDTH / 8;
  localparam int BURST_BYTES = BURST_LEN * BYTES;
  localparam int CNT_W       = $clog2(TXN_NUM + 1);
  localparam int OST_W       = $clog2(OST_DEPTH + 1);
  localparam int BEAT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  localparam logic [CNT_W-1:0]  TXN_MAX   = CNT_W'(TXN_NUM);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [OST_W-1:0]  OST_MAX   = OST_W'(OST_DEPTH);
  localparam logic [OST_W-1:0]  OST_ZERO  = OST_W'(0);
  localparam logic [OST_W-1:0]  OST_ONE   = OST_W'(1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);
  localparam logic [BEAT_W-1:0] BEAT_ZERO = BEAT_W'(0);
  localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Start address of burst number idx. The sum wraps at ADDR_WIDTH.
  function automatic logic [ADDR_WIDTH-1:0] burst_addr(input logic [CNT_W-1:0] idx);
    return START_ADDR + ADDR_WIDTH'(32'(idx) * BURST_BYTES);
  endfunction

  state_t                state_r, state_nxt_s;
  logic [CNT_W-1:0]      ar_cnt_r, ar_cnt_nxt_s;
  logic [CNT_W-1:0]      r_cnt_r, r_cnt_nxt_s;
  logic [OST_W-1:0]      ost_r, ost_nxt_s;
  logic [BEAT_W-1:0]     beat_cnt_r, beat_cnt_nxt_s;
  logic                  arvalid_r, rready_r, rd_done_r, rd_err_r, rd_err_nxt_s;
  logic [ADDR_WIDTH-1:0] araddr_r;
  logic [ID_WIDTH-1:0]   arid_r;
  logic                  ar_hs_s, r_hs_s, last_beat_s, burst_end_s;
  logic                  start_s, err_flag_s, data_bad_s;
  logic [ID_WIDTH-1:0]   exp_rid_s;

  assign ar_hs_s     = arvalid_r & axi_mst_arready;
  assign r_hs_s      = axi_mst_rvalid & rready_r;
  assign last_beat_s = (beat_cnt_r == BEAT_LAST);
  // A burst closes on rlast or on its final beat. Closing on either one means
  // a missing or early rlast still lets the session finish.
  assign burst_end_s = r_hs_s & (axi_mst_rlast | last_beat_s);
  assign exp_rid_s   = ID_WIDTH'(32'(r_cnt_r) % OST_DEPTH);

`ifdef EASYAXI_RD_DATA_CHECK_EN
  // Expected beat data: copies of the beat address, zero-extended to DATA_WIDTH.
  function automatic logic [DATA_WIDTH-1:0] beat_pattern(input logic [ADDR_WIDTH-1:0] addr);
    logic [DATA_WIDTH-1:0] pat;
    pat = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < DATA_WIDTH / ADDR_WIDTH; i++) begin
      pat[i*ADDR_WIDTH +: ADDR_WIDTH] = addr;
    end
    return pat;
  endfunction

  logic [ADDR_WIDTH-1:0] beat_addr_s;
  assign beat_addr_s = burst_addr(r_cnt_r) + ADDR_WIDTH'(32'(beat_cnt_r) * BYTES);
  assign data_bad_s  = (axi_mst_rdata != beat_pattern(beat_addr_s));
`else
  logic unused_rdata_s;
  assign unused_rdata_s = ^axi_mst_rdata;
  assign data_bad_s     = 1'b0;
`endif

  // Next-state logic: session FSM, counters and error detection.
  always_comb begin
    state_nxt_s    = state_r;
    ar_cnt_nxt_s   = ar_cnt_r;
    r_cnt_nxt_s    = r_cnt_r;
    ost_nxt_s      = ost_r;
    beat_cnt_nxt_s = beat_cnt_r;
    start_s        = 1'b0;
    err_flag_s     = 1'b0;
    case (state_r)
      IDLE: begin
        err_flag_s = axi_mst_rvalid;
        if (rd_en) begin
          start_s        = 1'b1;
          state_nxt_s    = RUN;
          ar_cnt_nxt_s   = CNT_ZERO;
          r_cnt_nxt_s    = CNT_ZERO;
          ost_nxt_s      = OST_ZERO;
          beat_cnt_nxt_s = BEAT_ZERO;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN, DRAIN: begin
        err_flag_s = r_hs_s & ((axi_mst_rresp != 2'b00) | (axi_mst_rid != exp_rid_s) |
                               (axi_mst_rlast != last_beat_s) | data_bad_s);
        if (ar_hs_s) begin
          ar_cnt_nxt_s = ar_cnt_r + CNT_ONE;
        end else begin
          ar_cnt_nxt_s = ar_cnt_r;
        end
        if (burst_end_s) begin
          beat_cnt_nxt_s = BEAT_ZERO;
          r_cnt_nxt_s    = (r_cnt_r != TXN_MAX) ? r_cnt_r + CNT_ONE : r_cnt_r;
        end else if (r_hs_s) begin
          beat_cnt_nxt_s = beat_cnt_r + BEAT_ONE;
        end else begin
          beat_cnt_nxt_s = beat_cnt_r;
        end
        case ({ar_hs_s, burst_end_s})
          2'b10:   ost_nxt_s = ost_r + OST_ONE;
          2'b01:   ost_nxt_s = (ost_r != OST_ZERO) ? ost_r - OST_ONE : ost_r;
          default: ost_nxt_s = ost_r;
        endcase
        // rd_en is not sampled here. A started session always runs to completion.
        if (state_r == RUN) begin
          state_nxt_s = (ar_cnt_nxt_s == TXN_MAX) ? DRAIN : RUN;
        end else begin
          state_nxt_s = (r_cnt_nxt_s == TXN_MAX) ? DONE : DRAIN;
        end
      end
      DONE: begin
        err_flag_s = axi_mst_rvalid;
        if (!rd_en) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
    rd_err_nxt_s = (start_s ? 1'b0 : rd_err_r) | err_flag_s;
  end

  // State, counter and output registers. The outputs are computed from the
  // next-state values, so each output reflects the state of the current cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      ar_cnt_r   <= CNT_ZERO;
      r_cnt_r    <= CNT_ZERO;
      ost_r      <= OST_ZERO;
      beat_cnt_r <= BEAT_ZERO;
      arvalid_r  <= 1'b0;
      araddr_r   <= {ADDR_WIDTH{1'b0}};
      arid_r     <= {ID_WIDTH{1'b0}};
      rready_r   <= 1'b0;
      rd_done_r  <= 1'b0;
      rd_err_r   <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      ar_cnt_r   <= ar_cnt_nxt_s;
      r_cnt_r    <= r_cnt_nxt_s;
      ost_r      <= ost_nxt_s;
      beat_cnt_r <= beat_cnt_nxt_s;
      // The AR payload changes only with ar_cnt, so it holds while arvalid waits.
      arvalid_r  <= (state_nxt_s == RUN) && (ost_nxt_s < OST_MAX) && (ar_cnt_nxt_s < TXN_MAX);
      araddr_r   <= burst_addr(ar_cnt_nxt_s);
      arid_r     <= ID_WIDTH'(32'(ar_cnt_nxt_s) % OST_DEPTH);
      rready_r   <= (state_nxt_s == RUN) || (state_nxt_s == DRAIN);
      rd_done_r  <= (state_nxt_s == DONE);
      rd_err_r   <= rd_err_nxt_s;
    end
  end

  assign rd_done         = rd_done_r;
  assign rd_err          = rd_err_r;
  assign axi_mst_arvalid = arvalid_r;
  assign axi_mst_arid    = arid_r;
  assign axi_mst_araddr  = araddr_r;
  assign axi_mst_arlen   = 8'(BURST_LEN - 1);
  assign axi_mst_arsize  = 3'($clog2(BYTES));
  assign axi_mst_arburst = 2'b01;
  assign axi_mst_rready  = rready_r;

endmodule
